stopwatch_ctrl: RTL and testbench

Sequencing controller for the stopwatch time counter. Turns single-cycle start/stop and lap/clear button pulses into run/pause/clear control. Divides the system clock into the one-second count-enable the counter consumes. Captures lap times into a small FIFO that a display or host drains via a valid/ready handshake. Sits between the debounced button logic and the sec/min/hour counter datapath.

---
 rtl/stopwatch_pkg.sv | 19 +
 rtl/lap_fifo.sv | 52 +++++
 rtl/stopwatch_ctrl.sv | 119 +++++++++++
 tb/tb_stopwatch_ctrl.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types for the stopwatch controller: state encoding, counter field widths
// and the lap time record.
package stopwatch_pkg;
  localparam int SEC_W  = 7;
  localparam int MIN_W  = 7;
  localparam int HOUR_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10
  } sw_state_e;

  typedef struct packed {
    logic [HOUR_W-1:0] hour;
    logic [MIN_W-1:0]  min;
    logic [SEC_W-1:0]  sec;
  } lap_time_t;
endpackage

// File: rtl/lap_fifo.sv
// Lap capture FIFO: synchronous, power-of-two depth, with flush.
// A push into a full FIFO is accepted only when a pop frees a slot on the same edge.
module lap_fifo
  import stopwatch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  lap_time_t     din_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output lap_time_t     dout_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);
  lap_time_t     mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic          pop_eff, push_eff;

  assign empty_o  = (cnt_q == '0);
  assign full_o   = (cnt_q == CW'(DEPTH));
  assign pop_eff  = pop_i && !empty_o;
  assign push_eff = push_i && (!full_o || pop_eff);
  assign count_o  = cnt_q;
  assign dout_o   = empty_o ? '0 : mem_q[rd_q];

  always_ff @(posedge clk) begin
    if (push_eff && !flush_i && !reset) mem_q[wr_q] <= din_i;
  end

  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_eff) wr_q <= wr_q + 1'b1;
      if (pop_eff)  rd_q <= rd_q + 1'b1;
      case ({push_eff, pop_eff})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: start/lap FSM, one-second prescaler and lap capture.
// Define STOPWATCH_ALARM_EN to enable the sticky alarm ring output.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV  = 100000000,
  parameter int LAP_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       btn_start,
  input  logic                       btn_lap,
  input  logic [SEC_W-1:0]           cur_sec,
  input  logic [MIN_W-1:0]           cur_min,
  input  logic [HOUR_W-1:0]          cur_hour,
  output logic                       tick_en,
  output logic                       clr,
  output logic                       rec_stb,
  output logic [1:0]                 state,
  output logic                       lap_valid,
  input  logic                       lap_ready,
  output logic [SEC_W-1:0]           lap_sec,
  output logic [MIN_W-1:0]           lap_min,
  output logic [HOUR_W-1:0]          lap_hour,
  output logic [$clog2(LAP_DEPTH):0] lap_count,
  output logic                       lap_ovf,
  input  logic [SEC_W-1:0]           alarm_sec,
  input  logic [MIN_W-1:0]           alarm_min,
  input  logic [HOUR_W-1:0]          alarm_hour,
  input  logic                       alarm_arm,
  output logic                       ring
);
  localparam int PW = $clog2(TICK_DIV);

  sw_state_e state_q;
  logic [PW-1:0] presc_q, presc_d;
  logic tick_en_q, clr_q, rec_stb_q, ovf_q;
  logic lap_act, do_lap, do_clr, presc_wrap, push, pop;
  logic fifo_full, fifo_empty;
  lap_time_t head, cur;

  assign cur = '{hour: cur_hour, min: cur_min, sec: cur_sec};

  always_comb begin
    // start wins when both buttons arrive together
    lap_act    = btn_lap && !btn_start;
    do_lap     = (state_q == ST_RUN) && lap_act;
    do_clr     = (state_q == ST_PAUSE) && lap_act;
    presc_wrap = (presc_q == PW'(TICK_DIV - 1));
    pop        = lap_valid && lap_ready;
    push       = do_lap && (!fifo_full || pop);
    presc_d    = presc_q;
    if (state_q == ST_IDLE || do_clr) presc_d = '0;
    else if (state_q == ST_RUN)       presc_d = presc_wrap ? '0 : presc_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      presc_q   <= '0;
      tick_en_q <= 1'b0;
      clr_q     <= 1'b0;
      rec_stb_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      tick_en_q <= (state_q == ST_RUN) && presc_wrap;
      clr_q     <= do_clr;
      rec_stb_q <= push;
      if (do_clr)              ovf_q <= 1'b0;
      else if (do_lap && !push) ovf_q <= 1'b1;
      case (state_q)
        ST_IDLE:  if (btn_start) state_q <= ST_RUN;
        ST_RUN:   if (btn_start) state_q <= ST_PAUSE;
        ST_PAUSE: if (btn_start) state_q <= ST_RUN;
                  else if (btn_lap) state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  lap_fifo #(.DEPTH(LAP_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .din_i   (cur),
    .pop_i   (pop),
    .flush_i (do_clr),
    .dout_o  (head),
    .count_o (lap_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign state     = state_q;
  assign tick_en   = tick_en_q;
  assign clr       = clr_q;
  assign rec_stb   = rec_stb_q;
  assign lap_ovf   = ovf_q;
  assign lap_valid = !fifo_empty;
  assign lap_sec   = head.sec;
  assign lap_min   = head.min;
  assign lap_hour  = head.hour;

`ifdef STOPWATCH_ALARM_EN
  logic ring_q;
  always_ff @(posedge clk) begin
    if (reset || do_clr) ring_q <= 1'b0;
    else if (state_q == ST_RUN && alarm_arm &&
             cur_sec == alarm_sec && cur_min == alarm_min && cur_hour == alarm_hour)
      ring_q <= 1'b1;
  end
  assign ring = ring_q;
`else
  logic unused_alarm;
  assign unused_alarm = ^{alarm_arm, alarm_sec, alarm_min, alarm_hour};
  assign ring = 1'b0;
`endif
endmodule

// File: tb/tb_stopwatch_ctrl.sv
module tb_stopwatch_ctrl;
  logic clk = 1'b0;
  logic reset, btn_start, btn_lap, lap_ready, alarm_arm;
  logic [6:0] cur_sec, cur_min, alarm_sec, alarm_min;
  logic [4:0] cur_hour, alarm_hour;
  logic tick_en, clr, rec_stb, lap_valid, lap_ovf, ring;
  logic [1:0] state;
  logic [6:0] lap_sec, lap_min;
  logic [4:0] lap_hour;
  logic [2:0] lap_count;
  int n_chk = 0;
  int n_err = 0;

`ifdef STOPWATCH_ALARM_EN
  localparam bit ALARM = 1'b1;
`else
  localparam bit ALARM = 1'b0;
`endif

  always #5 clk = ~clk;

  stopwatch_ctrl #(.TICK_DIV(4), .LAP_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .btn_start(btn_start), .btn_lap(btn_lap),
    .cur_sec(cur_sec), .cur_min(cur_min), .cur_hour(cur_hour),
    .tick_en(tick_en), .clr(clr), .rec_stb(rec_stb), .state(state),
    .lap_valid(lap_valid), .lap_ready(lap_ready),
    .lap_sec(lap_sec), .lap_min(lap_min), .lap_hour(lap_hour),
    .lap_count(lap_count), .lap_ovf(lap_ovf),
    .alarm_sec(alarm_sec), .alarm_min(alarm_min), .alarm_hour(alarm_hour),
    .alarm_arm(alarm_arm), .ring(ring)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; btn_start = 1'b0; btn_lap = 1'b0; lap_ready = 1'b0;
    cur_sec = '0; cur_min = '0; cur_hour = '0;
    alarm_sec = 7'd3; alarm_min = '0; alarm_hour = '0; alarm_arm = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst_state", state, 2'b00);
    chk("rst_tick", tick_en, 1'b0);
    chk("rst_clr", clr, 1'b0);
    chk("rst_rec", rec_stb, 1'b0);
    chk("rst_valid", lap_valid, 1'b0);
    chk("rst_count", lap_count, 3'd0);
    chk("rst_ovf", lap_ovf, 1'b0);
    chk("rst_lapsec", lap_sec, 7'd0);
    chk("rst_ring", ring, 1'b0);

    btn_start = 1'b1; tick(); btn_start = 1'b0;
    chk("run_state", state, 2'b01);
    chk("run_tick0", tick_en, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk("run_tick", tick_en, (k % 4 == 0));
      chk("run_noclr", clr, 1'b0);
    end

    for (int k = 1; k <= 5; k++) tick();
    btn_start = 1'b1; tick(); btn_start = 1'b0;
    chk("pause_state", state, 2'b10);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("pause_notick", tick_en, 1'b0);
    end
    btn_start = 1'b1; tick(); btn_start = 1'b0;
    chk("resume_state", state, 2'b01);
    chk("resume_t0", tick_en, 1'b0);
    tick();
    chk("resume_t1", tick_en, 1'b0);
    tick();
    chk("resume_t2", tick_en, 1'b1);

    cur_sec = 7'd5; cur_min = 7'd1; cur_hour = 5'd0;
    btn_lap = 1'b1; tick(); btn_lap = 1'b0;
    chk("lap1_rec", rec_stb, 1'b1);
    chk("lap1_valid", lap_valid, 1'b1);
    chk("lap1_count", lap_count, 3'd1);
    chk("lap1_sec", lap_sec, 7'd5);
    chk("lap1_min", lap_min, 7'd1);
    chk("lap1_hour", lap_hour, 5'd0);
    tick();
    chk("lap1_rec_off", rec_stb, 1'b0);
    lap_ready = 1'b1; tick(); lap_ready = 1'b0;
    chk("pop_valid", lap_valid, 1'b0);
    chk("pop_count", lap_count, 3'd0);
    chk("pop_sec", lap_sec, 7'd0);

    for (int i = 1; i <= 5; i++) begin
      cur_sec = 7'(10 + i);
      btn_lap = 1'b1; tick(); btn_lap = 1'b0;
      chk("fill_rec", rec_stb, (i <= 4));
      chk("fill_count", lap_count, (i < 4 ? i : 4));
    end
    chk("fill_ovf", lap_ovf, 1'b1);
    chk("fill_head", lap_sec, 7'd11);

    cur_sec = 7'd20; lap_ready = 1'b1; btn_lap = 1'b1; tick(); btn_lap = 1'b0;
    chk("pp_rec", rec_stb, 1'b1);
    chk("pp_count", lap_count, 3'd4);
    chk("pp_head", lap_sec, 7'd12);
    tick();
    chk("drain_13", lap_sec, 7'd13);
    tick();
    chk("drain_14", lap_sec, 7'd14);
    tick();
    chk("drain_20", lap_sec, 7'd20);
    chk("drain_cnt", lap_count, 3'd1);
    lap_ready = 1'b0;

    btn_start = 1'b1; tick(); btn_start = 1'b0;
    chk("p2_state", state, 2'b10);
    btn_lap = 1'b1; tick(); btn_lap = 1'b0;
    chk("clr_pulse", clr, 1'b1);
    chk("clr_state", state, 2'b00);
    chk("clr_valid", lap_valid, 1'b0);
    chk("clr_count", lap_count, 3'd0);
    chk("clr_ovf", lap_ovf, 1'b0);
    tick();
    chk("clr_off", clr, 1'b0);

    btn_lap = 1'b1; tick(); btn_lap = 1'b0;
    chk("idle_lap_state", state, 2'b00);
    chk("idle_lap_clr", clr, 1'b0);
    chk("idle_lap_cnt", lap_count, 3'd0);

    btn_start = 1'b1; btn_lap = 1'b1; tick(); btn_start = 1'b0; btn_lap = 1'b0;
    chk("both_state", state, 2'b01);
    chk("both_rec", rec_stb, 1'b0);
    tick();
    chk("both_cnt", lap_count, 3'd0);

    cur_sec = 7'd0; cur_min = 7'd0; cur_hour = 5'd0; alarm_arm = 1'b1;
    tick();
    chk("ring_pre", ring, 1'b0);
    cur_sec = 7'd3; tick();
    chk("ring_rise", ring, ALARM);
    cur_sec = 7'd4; tick();
    chk("ring_hold", ring, ALARM);
    btn_start = 1'b1; tick(); btn_start = 1'b0;
    tick();
    chk("ring_pause", ring, ALARM);
    btn_lap = 1'b1; tick(); btn_lap = 1'b0;
    chk("ring_clr", ring, 1'b0);
    chk("ring_clr_st", state, 2'b00);
    alarm_arm = 1'b0;

    btn_start = 1'b1; tick(); btn_start = 1'b0;
    btn_lap = 1'b1; tick(); btn_lap = 1'b0;
    chk("mr_cnt1", lap_count, 3'd1);
    reset = 1'b1; btn_lap = 1'b1; tick(); reset = 1'b0; btn_lap = 1'b0;
    chk("mr_state", state, 2'b00);
    chk("mr_clr", clr, 1'b0);
    chk("mr_cnt0", lap_count, 3'd0);
    chk("mr_rec", rec_stb, 1'b0);

    btn_start = 1'b1; tick(); btn_start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("mr_tick", tick_en, (k == 4));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
